// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-fetch front end:
//   fetch_state_e : fetch FSM state encoding (BOOT, RUN, FAULT)
//   PC_INCR       : byte distance between sequential instructions
//   sext_word_off : sign-extends a 16-bit word offset to a 32-bit byte offset
// -----------------------------------------------------------------------------
package mips_pkg;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_FAULT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] PC_INCR = 32'd4;

   // beq immediates count words; the adder works in bytes.
   function automatic logic [31:0] sext_word_off(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit_if
// Control and status bundle between the decode/execute side (master) and the
// fetch unit (slave).
//   master -> slave : stall, branch_taken, branch_imm, jump, jump_index
//   slave -> master : pc, pc_plus4, fetch_valid, fault, fetch_count
// -----------------------------------------------------------------------------
interface pc_fetch_unit_if;

   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_imm;
   logic        jump;
   logic [25:0] jump_index;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic        fault;
   logic [15:0] fetch_count;

   modport master (
      output stall, branch_taken, branch_imm, jump, jump_index,
      input  pc, pc_plus4, fetch_valid, fault, fetch_count
   );

   modport slave (
      input  stall, branch_taken, branch_imm, jump, jump_index,
      output pc, pc_plus4, fetch_valid, fault, fetch_count
   );

endinterface

// File: rtl/next_pc_logic.sv
// -----------------------------------------------------------------------------
// next_pc_logic
// Combinational next-PC selection, priority jump > branch > sequential.
//   pc_plus4     : in,  address of the sequential successor
//   branch_taken : in,  beq condition met
//   branch_imm   : in,  signed word offset relative to pc_plus4
//   jump         : in,  j instruction
//   jump_index   : in,  26-bit word index inside the current 256 MB region
//   next_pc      : out, selected next fetch address (modulo 2^32)
// -----------------------------------------------------------------------------
module next_pc_logic
   import mips_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic        branch_taken,
   input  logic [15:0] branch_imm,
   input  logic        jump,
   input  logic [25:0] jump_index,
   output logic [31:0] next_pc
);

   always_comb begin
      if (jump) begin
         // The region bits come from pc_plus4, not pc, matching MIPS j semantics.
         next_pc = {pc_plus4[31:28], jump_index, 2'b00};
      end else if (branch_taken) begin
         next_pc = pc_plus4 + sext_word_off(branch_imm);
      end else begin
         next_pc = pc_plus4;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Program counter, fetch FSM, legality check and accepted-instruction counter.
//   clk  : in, rising-edge clock
//   rst  : in, asynchronous active-high reset
//   bus  : slave side of pc_fetch_unit_if (redirect/stall in, pc/status out)
// Parameters:
//   RESET_PC   : byte address loaded on reset
//   IMEM_WORDS : number of valid instruction words (indices 0..IMEM_WORDS-1)
// -----------------------------------------------------------------------------
module pc_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 45
) (
   input  logic            clk,
   input  logic            rst,
   pc_fetch_unit_if.slave  bus
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [15:0]  fetch_count_q, fetch_count_d;
   logic [31:0]  pc_plus4;
   logic [31:0]  next_pc;
   logic         pc_legal;
   logic         fetch_valid;

   assign pc_plus4 = pc_q + PC_INCR;
   assign pc_legal = (pc_q[1:0] == 2'b00) && ({2'b00, pc_q[31:2]} < IMEM_WORDS);

   next_pc_logic u_next_pc (
      .pc_plus4     (pc_plus4),
      .branch_taken (bus.branch_taken),
      .branch_imm   (bus.branch_imm),
      .jump         (bus.jump),
      .jump_index   (bus.jump_index),
      .next_pc      (next_pc)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_count_d = fetch_count_q;
      fetch_valid   = 1'b0;

      unique case (state_q)
         S_BOOT: state_d = S_RUN;
         S_RUN: begin
            fetch_valid = pc_legal;
            // Legality wins over stall: a bad pc faults even while stalled.
            if (!pc_legal) begin
               state_d = S_FAULT;
            end else if (!bus.stall) begin
               pc_d          = next_pc;
               fetch_count_d = fetch_count_q + 16'd1;
            end
         end
         S_FAULT: ;
         default: state_d = S_BOOT;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_BOOT;
         pc_q          <= RESET_PC;
         fetch_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign bus.pc          = pc_q;
   assign bus.pc_plus4    = pc_plus4;
   assign bus.fetch_valid = fetch_valid;
   assign bus.fault       = (state_q == S_FAULT);
   assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Self-checking bench: directed vector table, hand-written fault/reset/wrap
// sequences, and a randomized run against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

   localparam int unsigned WORDS = 45;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pc_fetch_unit_if bus ();
   pc_fetch_unit_if bus_mis ();

   pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS)) dut (
      .clk (clk), .rst (rst), .bus (bus)
   );

   pc_fetch_unit #(.RESET_PC(32'h2), .IMEM_WORDS(WORDS)) dut_mis (
      .clk (clk), .rst (rst), .bus (bus_mis)
   );

   int tests  = 0;
   int errors = 0;

   // Reference model: architectural view only (pc, count, booting, faulted).
   logic [31:0] m_pc;
   logic [15:0] m_cnt;
   bit          m_boot;
   bit          m_fault;

   typedef struct {
      bit          stall;
      bit          br;
      logic [15:0] imm;
      bit          j;
      logic [25:0] ji;
      logic [31:0] exp_pc;
      logic [15:0] exp_cnt;
      bit          exp_valid;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic bit m_legal(input logic [31:0] a);
      return (a % 4 == 0) && (a / 4 < WORDS);
   endfunction

   task automatic model_step(input bit s, input bit b, input logic [15:0] imm,
                             input bit j, input logic [25:0] ji);
      logic [31:0] seq;
      if (m_fault) return;
      if (m_boot) begin
         m_boot = 1'b0;
         return;
      end
      if (!m_legal(m_pc)) begin
         m_fault = 1'b1;
         return;
      end
      if (s) return;
      m_cnt = m_cnt + 16'd1;
      seq   = m_pc + 32'd4;
      if (j)      m_pc = (seq & 32'hF000_0000) + ({6'd0, ji} * 32'd4);
      else if (b) m_pc = seq + (32'(signed'(imm)) * 32'd4);
      else        m_pc = seq;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".pc"},    bus.pc,          m_pc);
      check({tag, ".cnt"},   32'(bus.fetch_count), 32'(m_cnt));
      check({tag, ".valid"}, 32'(bus.fetch_valid),
            32'(!m_boot && !m_fault && m_legal(m_pc)));
      check({tag, ".fault"}, 32'(bus.fault),   32'(m_fault));
      check({tag, ".p4"},    bus.pc_plus4,    m_pc + 32'd4);
   endtask

   // Drive one cycle of inputs, advance the model, and stop #1 after the edge.
   task automatic apply(input bit s, input bit b, input logic [15:0] imm,
                        input bit j, input logic [25:0] ji);
      bus.stall        = s;
      bus.branch_taken = b;
      bus.branch_imm   = imm;
      bus.jump         = j;
      bus.jump_index   = ji;
      model_step(s, b, imm, j, ji);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.jump = 1'b0;
      bus.branch_imm = '0; bus.jump_index = '0;
      #1;
      // No clock edge yet: these values prove the reset is asynchronous.
      check("rst_async.pc",    bus.pc,                 32'h0);
      check("rst_async.cnt",   32'(bus.fetch_count),   32'h0);
      check("rst_async.fault", 32'(bus.fault),         32'h0);
      check("rst_async.valid", 32'(bus.fetch_valid),   32'h0);
      @(negedge clk);
      rst = 1'b0;
      m_pc = 32'h0; m_cnt = 16'h0; m_boot = 1'b1; m_fault = 1'b0;
      check_model("boot");
   endtask

   initial begin
      bus_mis.stall = 1'b0; bus_mis.branch_taken = 1'b0; bus_mis.jump = 1'b0;
      bus_mis.branch_imm = '0; bus_mis.jump_index = '0;

      //             stall br imm       j  ji      pc     cnt  valid
      vecs[0]  = '{0, 0, 16'h0,    0, 26'h0,  32'h00, 16'd0,  1};
      vecs[1]  = '{0, 0, 16'h0,    0, 26'h0,  32'h04, 16'd1,  1};
      vecs[2]  = '{0, 0, 16'h0,    0, 26'h0,  32'h08, 16'd2,  1};
      vecs[3]  = '{0, 0, 16'h0,    0, 26'h0,  32'h0C, 16'd3,  1};
      vecs[4]  = '{0, 0, 16'h0,    0, 26'h0,  32'h10, 16'd4,  1};
      vecs[5]  = '{1, 0, 16'h0,    1, 26'h20, 32'h10, 16'd4,  1};
      vecs[6]  = '{1, 0, 16'h0,    1, 26'h20, 32'h10, 16'd4,  1};
      vecs[7]  = '{1, 0, 16'h0,    1, 26'h20, 32'h10, 16'd4,  1};
      vecs[8]  = '{0, 0, 16'h0,    0, 26'h0,  32'h14, 16'd5,  1};
      vecs[9]  = '{0, 0, 16'h0,    1, 26'hF,  32'h3C, 16'd6,  1};
      vecs[10] = '{0, 1, 16'h0003, 0, 26'h0,  32'h4C, 16'd7,  1};
      vecs[11] = '{0, 0, 16'h0,    1, 26'h10, 32'h40, 16'd8,  1};
      vecs[12] = '{0, 1, 16'hFFFC, 0, 26'h0,  32'h34, 16'd9,  1};
      vecs[13] = '{0, 0, 16'h0,    1, 26'h12, 32'h48, 16'd10, 1};
      vecs[14] = '{0, 1, 16'h0005, 1, 26'hF,  32'h3C, 16'd11, 1};
      vecs[15] = '{0, 0, 16'h0,    1, 26'h12, 32'h48, 16'd12, 1};
      vecs[16] = '{0, 0, 16'h0,    1, 26'hF,  32'h3C, 16'd13, 1};

      do_reset();
      check("mis_boot.pc",    bus_mis.pc,                32'h2);
      check("mis_boot.valid", 32'(bus_mis.fetch_valid),  32'h0);

      // Directed table.
      for (int i = 0; i < 17; i++) begin
         apply(vecs[i].stall, vecs[i].br, vecs[i].imm, vecs[i].j, vecs[i].ji);
         check($sformatf("vec%0d.pc", i),    bus.pc,               vecs[i].exp_pc);
         check($sformatf("vec%0d.cnt", i),   32'(bus.fetch_count), 32'(vecs[i].exp_cnt));
         check($sformatf("vec%0d.valid", i), 32'(bus.fetch_valid), 32'(vecs[i].exp_valid));
         if (i == 0) begin
            check("mis_run.valid", 32'(bus_mis.fetch_valid), 32'h0);
            check("mis_run.fault", 32'(bus_mis.fault),       32'h0);
         end
         if (i == 1) check("mis_fault", 32'(bus_mis.fault), 32'h1);
      end
      check("mis_frozen.pc", bus_mis.pc, 32'h2);

      // Range fault: run off the end of a 45-word memory.
      apply(0, 0, 16'h0, 1, 26'h2A);
      check("rng.pc_a8", bus.pc, 32'hA8);
      apply(0, 0, 16'h0, 0, 26'h0);
      apply(0, 0, 16'h0, 0, 26'h0);
      apply(0, 0, 16'h0, 0, 26'h0);
      check("rng.pc_b4",    bus.pc,               32'hB4);
      check("rng.valid_b4", 32'(bus.fetch_valid), 32'h0);
      check("rng.nofault",  32'(bus.fault),       32'h0);
      apply(0, 0, 16'h0, 0, 26'h0);
      check("rng.fault", 32'(bus.fault), 32'h1);
      for (int i = 0; i < 10; i++) begin
         apply(i[0], 1, 16'h0002, ~i[0], 26'h4);
         check($sformatf("rng.frz%0d.pc", i),  bus.pc,               32'hB4);
         check($sformatf("rng.frz%0d.cnt", i), 32'(bus.fetch_count), 32'd17);
         check($sformatf("rng.frz%0d.flt", i), 32'(bus.fault),       32'h1);
      end
      do_reset();

      // Reset during a stalled redirect drops the redirect.
      apply(0, 0, 16'h0, 0, 26'h0);
      apply(0, 0, 16'h0, 0, 26'h0);
      apply(1, 0, 16'h0, 1, 26'h20);
      apply(1, 0, 16'h0, 1, 26'h20);
      do_reset();
      apply(0, 0, 16'h0, 0, 26'h0);
      check_model("rststall0");
      apply(0, 0, 16'h0, 0, 26'h0);
      check("rststall.pc", bus.pc, 32'h4);

      // Counter wrap.
      force dut.fetch_count_q = 16'hFFFF;
      #1;
      release dut.fetch_count_q;
      m_cnt = 16'hFFFF;
      apply(0, 0, 16'h0, 0, 26'h0);
      check("wrap.cnt", 32'(bus.fetch_count), 32'h0);
      check("wrap.pc",  bus.pc,               32'h8);

      // Randomized run against the reference model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0 || (m_fault && $urandom_range(0, 7) == 0)) begin
            do_reset();
         end else begin
            apply($urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0,
                  16'(int'($urandom_range(0, 16)) - 8),
                  $urandom_range(0, 9) == 0,
                  26'($urandom_range(0, 50)));
            check_model($sformatf("rnd%0d", i));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the byte address loaded into the PC on reset.
REQ-002 Parameter IMEM_WORDS, default 45, the number of valid instruction-memory words; legal word indices are 0..IMEM_WORDS-1.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port stall, input, 1 bit: hold the PC and suppress the update this cycle.
REQ-006 Port branch_taken, input, 1 bit: a beq condition is met; redirect to the branch target.
REQ-007 Port branch_imm, input, 16 bits: the raw beq immediate (signed word offset).
REQ-008 Port jump, input, 1 bit: a j instruction; redirect to the jump target.
REQ-009 Port jump_index, input, 26 bits: the raw j instruction index field.
REQ-010 Port pc, output, 32 bits: the current fetch byte address; drives the instruction-memory Address input.
REQ-011 Port pc_plus4, output, 32 bits: pc + 4, combinational.
REQ-012 Port fetch_valid, output, 1 bit: the instruction at pc is legitimate and may be executed.
REQ-013 Port fault, output, 1 bit: sticky; pc left the legal instruction range or is misaligned.
REQ-014 Port fetch_count, output, 16 bits: count of instructions accepted since reset.

Function
REQ-015 The block SHALL implement a 3-state FSM: BOOT, RUN, FAULT.
REQ-016 In BOOT: pc = RESET_PC, fetch_valid = 0, no PC update; the FSM moves to RUN on the next edge unconditionally.
REQ-017 In RUN: fetch_valid = 1 while pc is legal.
- "Accepted cycle" = RUN, stall = 0, pc legal.
- On each accepted cycle, pc SHALL load next_pc and fetch_count SHALL increment.
REQ-018 next_pc priority is jump > branch_taken > sequential.
- jump: {pc_plus4[31:28], jump_index, 2'b00}.
- branch: pc_plus4 + (sign_extend(branch_imm) << 2).
- else: pc_plus4.
REQ-019 All PC arithmetic is 32-bit modulo 2^32; a carry out is discarded.
REQ-020 When stall = 1 in RUN: pc, fetch_count and FSM state SHALL hold, and jump/branch_taken SHALL be ignored.
- The requester must re-present a redirect after the stall.
REQ-021 pc is legal iff pc[1:0] == 0 and pc[31:2] < IMEM_WORDS.
REQ-022 Illegal pc in RUN (checked every cycle, stall or not):
- fetch_valid SHALL be 0 that same cycle (combinational).
- The FSM SHALL enter FAULT on the next edge.
REQ-023 In FAULT: fault = 1, fetch_valid = 0, pc and fetch_count frozen; exit only via rst.
REQ-024 fetch_count SHALL wrap from 16'hFFFF to 16'h0000 without side effects.
REQ-025 jump and branch_taken asserted together SHALL take the jump target; no error is flagged.
REQ-026 The redirect applies with one-cycle latency: next_pc is visible on pc the cycle after the accepted cycle.

Reset
REQ-027 rst SHALL asynchronously force:
- state = BOOT, pc = RESET_PC, fetch_count = 0, fault = 0.
- fetch_valid = 0, since the FSM is in BOOT.
REQ-028 Assertion of rst mid-operation (including in FAULT or during a stall) SHALL abandon any pending redirect; no state survives reset.
REQ-029 After rst deasserts, the first accepted cycle SHALL occur no earlier than the second rising edge (BOOT lasts exactly one cycle).

Structure
REQ-030 The FSM state encoding, the state typedef and the constant 32'd4 SHALL live in a shared package mips_pkg; RESET_PC and IMEM_WORDS remain module parameters.
REQ-031 The next-PC computation (sequential/branch/jump muxing) SHALL be a combinational sub-module named next_pc_logic; the PC register, FSM, legality check and counter stay in pc_fetch_unit.

Verification
REQ-032 Reset release, no stall or redirect, 4 cycles:
- BOOT cycle: fetch_valid = 0, pc = 0x00.
- Then pc = 0x00, 0x04, 0x08, 0x0C on successive cycles, and fetch_count = 3 when pc = 0x0C.
REQ-033 Branch: pc = 0x3C, branch_taken = 1, branch_imm = 16'h0003 -> pc = 0x4C next cycle.
- Negative case: branch_imm = 16'hFFFC at pc = 0x40 -> pc = 0x34.
REQ-034 Jump: pc = 0x48, jump = 1, jump_index = 26'h00000F -> pc = 0x3C.
- Same cycle with branch_taken = 1, branch_imm = 16'h0005 -> pc still 0x3C.
REQ-035 Stall: pc = 0x10, stall = 1 for 3 cycles with jump = 1 -> pc stays 0x10 and fetch_count unchanged.
- Stall released with jump = 0 -> pc = 0x14.
REQ-036 Range fault: IMEM_WORDS = 45, sequential run reaches pc = 0xB4 (word 45) -> fetch_valid = 0 that cycle, fault = 1 next cycle.
- pc then frozen at 0xB4 for 10 cycles; rst pulse -> pc = 0x00, fault = 0, BOOT.
REQ-037 Misalignment and wrap:
- Jump target forced via RESET_PC = 32'h2 -> fault after BOOT.
- Preloaded fetch_count = 16'hFFFF (via force) plus one accepted cycle -> fetch_count = 0.
